// File: rtl/ooo_dbg_pkg.sv
// Shared debug-monitor types for the out-of-order core: monitor states, counter
// defaults and the commit-lane record used by the debug blocks.
package ooo_dbg_pkg;

  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned LANE_XLEN  = 32;
  localparam int unsigned LANE_REG_W = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2,
    StHang = 2'd3
  } mon_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic [LANE_REG_W-1:0] rd;
    logic [LANE_XLEN-1:0]  value;
    logic [31:0]           pc;
  } commit_lane_t;

endpackage

// File: rtl/mon_shadow_arf.sv
// Shadow architectural register file: N-lane write port (higher lane wins),
// one registered read/compare port, hardwired zero register.
module mon_shadow_arf #(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned ARCH_REGS    = 32,
  parameter int unsigned ZERO_REG     = 0,
  localparam int unsigned REG_W       = $clog2(ARCH_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [COMMIT_WIDTH-1:0]       wr_en,
  input  logic [COMMIT_WIDTH*REG_W-1:0] wr_addr,
  input  logic [COMMIT_WIDTH*XLEN-1:0]  wr_data,
  input  logic                          rd_en,
  input  logic [REG_W-1:0]              rd_addr,
  input  logic [XLEN-1:0]               rd_expect,
  output logic                          rd_valid,
  output logic                          rd_match,
  output logic [XLEN-1:0]               rd_data
);

  localparam logic [REG_W-1:0] ZeroIdx = REG_W'(ZERO_REG);

  logic [XLEN-1:0] regs_q [ARCH_REGS];
  logic [XLEN-1:0] regs_d [ARCH_REGS];
  logic [XLEN-1:0] rd_raw;
  logic            rd_valid_q, rd_match_q;
  logic [XLEN-1:0] rd_data_q;

  // Lanes are applied in ascending order so the highest lane lands last.
  always_comb begin
    regs_d = regs_q;
    if (clear) begin
      for (int i = 0; i < ARCH_REGS; i++) regs_d[i] = '0;
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (wr_en[k] && (wr_addr[k*REG_W +: REG_W] != ZeroIdx)) begin
          regs_d[wr_addr[k*REG_W +: REG_W]] = wr_data[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Reads see the pre-write contents: no same-cycle bypass.
  always_comb begin
    rd_raw = (rd_addr == ZeroIdx) ? '0 : regs_q[rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q     <= '{default: '0};
      rd_valid_q <= 1'b0;
      rd_match_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q  <= rd_raw;
        rd_match_q <= (rd_raw == rd_expect);
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_match = rd_match_q;
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/commit_progress_monitor.sv
// Commit-stream monitor: run/done/hang FSM, saturating progress counters,
// hang watchdog, lane-ordering check and a shadow ARF for register checks.
module commit_progress_monitor
  import ooo_dbg_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned ARCH_REGS    = 32,
  parameter int unsigned ZERO_REG     = 0,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned TIMEOUT_W    = 16,
  parameter int unsigned ROB_DEPTH    = 32,
  localparam int unsigned REG_W       = $clog2(ARCH_REGS),
  localparam int unsigned OCC_W       = $clog2(ROB_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [CNT_W-1:0]              target_commits,
  input  logic [TIMEOUT_W-1:0]          timeout_cycles,
  input  logic [COMMIT_WIDTH-1:0]       commit_valid,
  input  logic [COMMIT_WIDTH*REG_W-1:0] commit_arch_rd,
  input  logic [COMMIT_WIDTH-1:0]       commit_wen,
  input  logic [COMMIT_WIDTH*XLEN-1:0]  commit_value,
  input  logic [COMMIT_WIDTH*32-1:0]    commit_pc,
  input  logic [OCC_W-1:0]              rob_occupancy,
  input  logic                          chk_req,
  input  logic [REG_W-1:0]              chk_reg,
  input  logic [XLEN-1:0]               chk_expect,
  output logic                          chk_done,
  output logic                          chk_pass,
  output logic [XLEN-1:0]               chk_actual,
  output logic [1:0]                    state,
  output logic [CNT_W-1:0]              cycle_count,
  output logic [CNT_W-1:0]              commit_count,
  output logic [CNT_W-1:0]              idle_streak,
  output logic                          order_err,
  output logic [31:0]                   err_pc
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, commits_q, commits_d, streak_q, streak_d;
  logic             order_err_q, order_err_d;
  logic [31:0]      err_pc_q, err_pc_d;

  logic [CNT_W-1:0] nvalid, cycle_inc, commit_inc, streak_inc;
  logic [CNT_W:0]   commit_sum;
  logic             streak_clr, order_hit, lane_gap;
  logic [31:0]      hit_pc;

  // Saturating increments and the first out-of-order lane in this cycle.
  always_comb begin
    nvalid = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) nvalid = nvalid + CNT_W'(commit_valid[k]);
    commit_sum = {1'b0, commits_q} + {1'b0, nvalid};
    commit_inc = commit_sum[CNT_W] ? CntMax : commit_sum[CNT_W-1:0];
    cycle_inc  = (cycle_q == CntMax) ? cycle_q : cycle_q + CNT_W'(1);
    streak_inc = (streak_q == CntMax) ? streak_q : streak_q + CNT_W'(1);
    streak_clr = (|commit_valid) || (rob_occupancy == '0);

    order_hit = 1'b0;
    lane_gap  = 1'b0;
    hit_pc    = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (commit_valid[k] && lane_gap && !order_hit) begin
        order_hit = 1'b1;
        hit_pc    = commit_pc[k*32 +: 32];
      end
      if (!commit_valid[k]) lane_gap = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    commits_d   = commits_q;
    streak_d    = streak_q;
    order_err_d = order_err_q;
    err_pc_d    = err_pc_q;
    if (!enable) begin
      state_d     = StIdle;
      cycle_d     = '0;
      commits_d   = '0;
      streak_d    = '0;
      order_err_d = 1'b0;
      err_pc_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d     = StRun;
          cycle_d     = '0;
          commits_d   = '0;
          streak_d    = '0;
          order_err_d = 1'b0;
          err_pc_d    = '0;
        end
        StRun: begin
          cycle_d   = cycle_inc;
          commits_d = commit_inc;
          streak_d  = streak_clr ? '0 : streak_inc;
          if (order_hit && !order_err_q) begin
            order_err_d = 1'b1;
            err_pc_d    = hit_pc;
          end
          // DONE outranks HANG when both fire together.
          if ((target_commits != '0) && (commit_inc >= target_commits)) begin
            state_d = StDone;
          end else if ((timeout_cycles != '0) && !streak_clr &&
                       (streak_inc >= CNT_W'(timeout_cycles))) begin
            state_d = StHang;
          end
        end
        default: ;  // DONE and HANG hold everything until enable drops
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cycle_q     <= '0;
      commits_q   <= '0;
      streak_q    <= '0;
      order_err_q <= 1'b0;
      err_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      commits_q   <= commits_d;
      streak_q    <= streak_d;
      order_err_q <= order_err_d;
      err_pc_q    <= err_pc_d;
    end
  end

  logic                    arf_clear;
  logic [COMMIT_WIDTH-1:0] arf_wr_en;

  assign arf_clear = !enable || (state_q == StIdle);
  assign arf_wr_en = (state_q == StRun) ? (commit_valid & commit_wen) : '0;

  mon_shadow_arf #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .XLEN         (XLEN),
    .ARCH_REGS    (ARCH_REGS),
    .ZERO_REG     (ZERO_REG)
  ) u_shadow_arf (
    .clk       (clk),
    .reset     (reset),
    .clear     (arf_clear),
    .wr_en     (arf_wr_en),
    .wr_addr   (commit_arch_rd),
    .wr_data   (commit_value),
    .rd_en     (chk_req),
    .rd_addr   (chk_reg),
    .rd_expect (chk_expect),
    .rd_valid  (chk_done),
    .rd_match  (chk_pass),
    .rd_data   (chk_actual)
  );

  assign state        = state_q;
  assign cycle_count  = cycle_q;
  assign commit_count = commits_q;
  assign idle_streak  = streak_q;
  assign order_err    = order_err_q;
  assign err_pc       = err_pc_q;

endmodule

// File: tb/tb_commit_progress_monitor.sv
// Directed bench for commit_progress_monitor: a behavioural model checked every
// cycle, plus literal expectations taken from the scenarios.
module tb_commit_progress_monitor;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [31:0] target_commits;
  logic [15:0] timeout_cycles;
  logic [1:0]  commit_valid, commit_wen;
  logic [9:0]  commit_arch_rd;
  logic [63:0] commit_value, commit_pc;
  logic [5:0]  rob_occupancy;
  logic        chk_req;
  logic [4:0]  chk_reg;
  logic [31:0] chk_expect;
  logic        chk_done, chk_pass, order_err;
  logic [31:0] chk_actual, cycle_count, commit_count, idle_streak, err_pc;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;

  commit_progress_monitor u_dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .target_commits (target_commits),
    .timeout_cycles (timeout_cycles),
    .commit_valid   (commit_valid),
    .commit_arch_rd (commit_arch_rd),
    .commit_wen     (commit_wen),
    .commit_value   (commit_value),
    .commit_pc      (commit_pc),
    .rob_occupancy  (rob_occupancy),
    .chk_req        (chk_req),
    .chk_reg        (chk_reg),
    .chk_expect     (chk_expect),
    .chk_done       (chk_done),
    .chk_pass       (chk_pass),
    .chk_actual     (chk_actual),
    .state          (state),
    .cycle_count    (cycle_count),
    .commit_count   (commit_count),
    .idle_streak    (idle_streak),
    .order_err      (order_err),
    .err_pc         (err_pc)
  );

  always #5 clk = ~clk;

  // Behavioural model: 0=IDLE 1=RUN 2=DONE 3=HANG
  int          m_state;
  logic [31:0] m_cycle, m_commits, m_streak, m_err_pc, m_chk_actual;
  logic        m_order_err, m_chk_done, m_chk_pass;
  logic [31:0] m_arf [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a, input int b);
    longint s = longint'(a) + longint'(b);
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  task automatic model_clear();
    m_state = 0;
    m_cycle = 0; m_commits = 0; m_streak = 0;
    m_order_err = 0; m_err_pc = 0;
    for (int i = 0; i < 32; i++) m_arf[i] = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_chk_done = 0; m_chk_pass = 0; m_chk_actual = 0;
  endtask

  task automatic model_step();
    int n;
    if (!reset) begin
      model_reset();
      return;
    end
    m_chk_done = chk_req;
    if (chk_req) begin
      m_chk_actual = (chk_reg == 0) ? 32'd0 : m_arf[chk_reg];
      m_chk_pass   = (m_chk_actual == chk_expect);
    end
    if (!enable) begin
      model_clear();
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      n = int'(commit_valid[0]) + int'(commit_valid[1]);
      m_cycle   = sat_add(m_cycle, 1);
      m_commits = sat_add(m_commits, n);
      m_streak  = (n > 0 || rob_occupancy == 0) ? 32'd0 : sat_add(m_streak, 1);
      for (int k = 0; k < 2; k++) begin
        if (commit_valid[k] && commit_wen[k] && commit_arch_rd[k*5 +: 5] != 0)
          m_arf[commit_arch_rd[k*5 +: 5]] = commit_value[k*32 +: 32];
      end
      if (commit_valid[1] && !commit_valid[0] && !m_order_err) begin
        m_order_err = 1;
        m_err_pc    = commit_pc[63:32];
      end
      if (target_commits != 0 && m_commits >= target_commits) m_state = 2;
      else if (timeout_cycles != 0 && n == 0 && rob_occupancy != 0 &&
               m_streak >= 32'(timeout_cycles)) m_state = 3;
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    check("state", 32'(state), 32'(m_state));
    check("cycle_count", cycle_count, m_cycle);
    check("commit_count", commit_count, m_commits);
    check("idle_streak", idle_streak, m_streak);
    check("order_err", 32'(order_err), 32'(m_order_err));
    check("err_pc", err_pc, m_err_pc);
    check("chk_done", 32'(chk_done), 32'(m_chk_done));
    check("chk_pass", 32'(chk_pass), 32'(m_chk_pass));
    check("chk_actual", chk_actual, m_chk_actual);
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic quiet();
    commit_valid = 0; commit_wen = 0; commit_arch_rd = 0;
    commit_value = 0; commit_pc = 0; chk_req = 0; chk_reg = 0; chk_expect = 0;
  endtask

  task automatic lane(input int k, input logic wen, input logic [4:0] rd,
                      input logic [31:0] val, input logic [31:0] pc);
    commit_valid[k] = 1'b1;
    commit_wen[k] = wen;
    commit_arch_rd[k*5 +: 5] = rd;
    commit_value[k*32 +: 32] = val;
    commit_pc[k*32 +: 32] = pc;
  endtask

  task automatic ask(input logic [4:0] r, input logic [31:0] e);
    chk_req = 1'b1; chk_reg = r; chk_expect = e;
  endtask

  task automatic restart();
    quiet(); enable = 0; tick();
    enable = 1; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 0; enable = 0; target_commits = 0; timeout_cycles = 0; rob_occupancy = 0;
    quiet();
    model_reset();
    tick(); tick();
    check("reset_state", 32'(state), 32'd0);
    check("reset_chk_done", 32'(chk_done), 32'd0);
    reset = 1;
    tick();

    // Stream x1=10,x2=5,x3=15,x4=5 with target 4.
    target_commits = 4; rob_occupancy = 2;
    enable = 1; tick();
    check("run_entered", 32'(state), 32'd1);
    lane(0, 1, 1, 10, 32'h00); lane(1, 1, 2, 5, 32'h04); tick();
    quiet(); lane(0, 1, 3, 15, 32'h08); lane(1, 1, 4, 5, 32'h0C); tick();
    quiet();
    check("done_state", 32'(state), 32'd2);
    check("done_commits", commit_count, 32'd4);
    lane(0, 1, 1, 99, 32'h10); ask(1, 10); tick();
    quiet(); ask(2, 5); tick();
    check("x1_pass", 32'(chk_pass), 32'd1);
    ask(3, 15); tick();
    ask(4, 5); tick();
    ask(3, 14); tick();
    check("x3_bad_pass", 32'(chk_pass), 32'd0);
    check("x3_bad_actual", chk_actual, 32'd15);
    ask(1, 10); tick();
    check("frozen_x1", chk_actual, 32'd10);
    quiet(); tick();
    check("done_frozen_commits", commit_count, 32'd4);

    // Watchdog: occupancy 3, no commits, limit 8.
    target_commits = 0; timeout_cycles = 8; rob_occupancy = 3;
    restart();
    for (int i = 0; i < 7; i++) tick();
    check("pre_hang_state", 32'(state), 32'd1);
    tick();
    check("hang_state", 32'(state), 32'd3);
    check("hang_cycles", cycle_count, 32'd8);
    check("hang_streak", idle_streak, 32'd8);
    tick(); tick(); tick();
    check("hang_frozen", cycle_count, 32'd8);

    // Ordering, same-rd priority, zero register, no-bypass read.
    timeout_cycles = 0; rob_occupancy = 4;
    restart();
    lane(1, 1, 6, 1, 32'h0C); tick();
    quiet();
    check("order_err", 32'(order_err), 32'd1);
    check("err_pc_first", err_pc, 32'h0C);
    lane(0, 0, 0, 0, 32'h10); tick();
    quiet(); lane(1, 0, 0, 0, 32'h20); tick();
    quiet();
    check("err_pc_sticky", err_pc, 32'h0C);
    lane(0, 1, 5, 7, 32'h24); lane(1, 1, 5, 9, 32'h28); tick();
    quiet(); ask(5, 9); tick();
    quiet();
    check("x5_high_lane", chk_actual, 32'd9);
    lane(0, 1, 0, 42, 32'h2C); tick();
    quiet(); ask(0, 0); tick();
    quiet();
    check("x0_zero", chk_actual, 32'd0);
    check("x0_pass", 32'(chk_pass), 32'd1);
    lane(0, 1, 1, 10, 32'h30); ask(1, 10); tick();
    quiet();
    check("no_bypass_old", chk_actual, 32'd0);
    ask(1, 10); tick();
    quiet();
    check("after_commit", chk_actual, 32'd10);
    tick();
    check("chk_done_pulse", 32'(chk_done), 32'd0);

    // Asynchronous reset mid-run.
    restart();
    lane(0, 1, 7, 3, 32'h40); lane(1, 1, 8, 4, 32'h44); tick();
    quiet(); lane(0, 1, 9, 5, 32'h48); tick();
    quiet();
    check("pre_reset_commits", commit_count, 32'd3);
    #2 reset = 0;
    model_reset();
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_commits", commit_count, 32'd0);
    check("async_cycles", cycle_count, 32'd0);
    check("async_chk_actual", chk_actual, 32'd0);
    @(negedge clk);
    reset = 1;
    tick();
    check("rerun_state", 32'(state), 32'd1);
    tick();
    check("rerun_cycles", cycle_count, 32'd1);
    check("rerun_commits", commit_count, 32'd0);
    ask(7, 0); tick();
    quiet();
    check("rerun_arf_clear", chk_actual, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
